// File: rtl/axi_wr_burst.sv
// axi_wr_burst: write-side DMA engine. Takes the 512-bit result-buffer beat
// stream and writes it to host memory as AXI4 INCR bursts of up to 64 beats
// (4 KB each), starting at a 4 KB-aligned destination address.
//
// Handshake rule for every channel (upstream beat, AW, W, B): a transfer
// happens on the rising edge where valid and ready are both high; a valid
// source holds its payload stable until that edge.
module axi_wr_burst #(
  parameter int MAX_OUTST   = 8,
  parameter int BURST_BEATS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  dest_addr,
  input  logic [31:0]  decompression_length,
  input  logic [511:0] data_i,
  input  logic         valid_i,
  input  logic         last_i,
  output logic         ready_o,
  output logic [63:0]  m_awaddr,
  output logic [7:0]   m_awlen,
  output logic         m_awvalid,
  input  logic         m_awready,
  output logic [511:0] m_wdata,
  output logic [63:0]  m_wstrb,
  output logic         m_wlast,
  output logic         m_wvalid,
  input  logic         m_wready,
  input  logic [1:0]   m_bresp,
  input  logic         m_bvalid,
  output logic         m_bready,
  output logic         done,
  output logic         error,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [25:0] BURST_W  = 26'(BURST_BEATS);
  localparam logic [7:0]  FULL_LEN = 8'(BURST_BEATS - 1);
  localparam logic [3:0]  OUTST_W  = 4'(MAX_OUTST);

  state_t       state_q, state_d;
  logic         hold_q, hold_d;       // burst finished, waiting for a free outstanding slot
  logic [3:0]   outst_q, outst_d;
  logic [63:0]  aw_addr_q;
  logic [25:0]  beats_left_q;         // beats of the transfer not yet written
  logic [7:0]   awlen_q;
  logic [7:0]   beat_q;               // beat index inside the current burst
  logic [5:0]   len_lo_q;
  logic         error_q;
  logic         done_q;

  logic w_active, aw_hs, w_hs, b_hs, last_beat;

  // W pass-through, AW request and handshake decode.
  always_comb begin
    w_active  = (state_q == S_DATA) && !hold_q;
    m_wvalid  = valid_i & w_active;
    ready_o   = m_wready & w_active;
    m_wdata   = data_i;
    m_wlast   = (beat_q == awlen_q);
    last_beat = (beats_left_q == 26'd1);
    m_awvalid = (state_q == S_ADDR);
    m_awaddr  = aw_addr_q;
    m_awlen   = (beats_left_q >= BURST_W) ? FULL_LEN : 8'(beats_left_q - 26'd1);
    m_bready  = 1'b1;
    aw_hs     = m_awvalid & m_awready;
    w_hs      = m_wvalid & m_wready;
    b_hs      = m_bvalid & m_bready;
    done        = done_q;
    error       = error_q;
    dbg_state_o = state_q;
  end

  // Byte strobes: a partial final beat only enables its low len[5:0] bytes.
  always_comb begin
    m_wstrb = '1;
    if (last_beat && (len_lo_q != 6'd0)) begin
      for (int i = 0; i < 64; i++) begin
        m_wstrb[i] = (6'(i) < len_lo_q);
      end
    end
  end

  // Outstanding-burst counter: AW adds, B removes, both together cancel.
  always_comb begin
    outst_d = outst_q;
    if (aw_hs && !(b_hs && outst_q != 4'd0)) begin
      outst_d = outst_q + 4'd1;
    end else if (!aw_hs && b_hs && outst_q != 4'd0) begin
      outst_d = outst_q - 4'd1;
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (decompression_length == 32'd0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          state_d = S_DATA;
          hold_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (hold_q) begin
          if (outst_q < OUTST_W) begin
            state_d = S_ADDR;
            hold_d  = 1'b0;
          end
        end else if (w_hs && m_wlast) begin
          if (last_beat) begin
            state_d = S_DRAIN;
          end else if (outst_d < OUTST_W) begin
            state_d = S_ADDR;
          end else begin
            hold_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == 4'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and sticky status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_q       <= 1'b0;
      outst_q      <= 4'd0;
      aw_addr_q    <= 64'd0;
      beats_left_q <= 26'd0;
      awlen_q      <= 8'd0;
      beat_q       <= 8'd0;
      len_lo_q     <= 6'd0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      outst_q <= outst_d;
      done_q  <= (state_q == S_DONE);
      if (state_q == S_IDLE && start) begin
        aw_addr_q    <= dest_addr & ~64'hFFF;
        beats_left_q <= decompression_length[31:6] + {25'd0, |decompression_length[5:0]};
        len_lo_q     <= decompression_length[5:0];
        error_q      <= 1'b0;
      end
      if (aw_hs) begin
        awlen_q   <= m_awlen;
        beat_q    <= 8'd0;
        aw_addr_q <= aw_addr_q + 64'd4096;
      end
      if (w_hs) begin
        beats_left_q <= beats_left_q - 26'd1;
        beat_q       <= beat_q + 8'd1;
        if (last_i != m_wlast) begin
          error_q <= 1'b1;
        end
      end
      if (b_hs && m_bresp != 2'b00) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule
